// File: rtl/kbd_spi_port_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | kbd_spi_port_reader                                                      |
// | SPI receiver for controller key/joystick frames; answers #FE/#1F reads.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module kbd_spi_port_reader #(
  parameter int         SYNC_STAGES = 2,
  parameter int         FRAME_BITS  = 72,
  parameter logic [7:0] KJ_ADDR     = 8'h1F
) (
  input  logic        CLK_14MHZ,
  input  logic        CPU_RESET,
  input  logic        KBD_CLK,
  input  logic        KBD_CS,
  input  logic        KBD_DI,
  input  logic [15:0] A,
  input  logic        IORD_N,
  input  logic        TAPE_IN,
  output logic        FE_OE,
  output logic        KJ_OE,
  output logic [7:0]  DOUT,
  output logic        FRAME_OK,
  output logic        FRAME_ERR
);

  localparam logic [6:0] c_FRAME_CNT = 7'(FRAME_BITS);
  localparam logic [6:0] c_CNT_MAX   = 7'd127;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_di_sync;
  logic                   r_clk_prev;
  logic                   r_cs_prev;

  logic w_clk_s, w_cs_s, w_di_s;
  logic w_clk_rise, w_cs_fall, w_cs_rise;

  state_t r_state, w_next;
  logic   w_clr_cnt, w_shift_en, w_commit, w_err;

  logic [6:0] r_cnt;
  logic [4:0] r_row_sr [8];
  logic [7:0] r_joy_sr;
  logic [4:0] r_rows [8];
  logic [7:0] r_joy;
  logic [4:0] w_keys;
  logic [3:0] w_byte_idx;
  logic [2:0] w_bit_pos;

  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
    if (!CPU_RESET) begin
      r_clk_sync <= '1;
      r_cs_sync  <= '1;
      r_di_sync  <= '1;
      r_clk_prev <= 1'b1;
      r_cs_prev  <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], KBD_CLK};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], KBD_CS};
      r_di_sync  <= {r_di_sync[SYNC_STAGES-2:0], KBD_DI};
      r_clk_prev <= w_clk_s;
      r_cs_prev  <= w_cs_s;
    end
  end

  assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_di_s     = r_di_sync[SYNC_STAGES-1];
  assign w_clk_rise = w_clk_s & ~r_clk_prev;
  assign w_cs_fall  = ~w_cs_s & r_cs_prev;
  assign w_cs_rise  = w_cs_s & ~r_cs_prev;

  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
    if (!CPU_RESET) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_clr_cnt  = 1'b0;
    w_shift_en = 1'b0;
    w_commit   = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_next    = ST_SHIFT;
          w_clr_cnt = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_cs_rise) begin
          if (r_cnt == c_FRAME_CNT) begin
            w_next = ST_COMMIT;
          end else begin
            w_next = ST_IDLE;
            w_err  = 1'b1;
          end
        end else if (w_clk_rise && !w_cs_s) begin
          w_shift_en = 1'b1;
        end
      end
      ST_COMMIT: begin
        // Shadow update is held off while a read is in progress.
        if (IORD_N) begin
          w_next   = ST_IDLE;
          w_commit = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Bits 7..5 of each row byte arrive at positions 0..2 and are dropped;
  // only the five key bits per row and the full joystick byte are kept.
  assign w_byte_idx = r_cnt[6:3];
  assign w_bit_pos  = r_cnt[2:0];

  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
    if (!CPU_RESET) begin
      r_cnt     <= '0;
      r_joy_sr  <= '0;
      r_joy     <= 8'h00;
      FRAME_OK  <= 1'b0;
      FRAME_ERR <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        r_row_sr[k] <= '0;
        r_rows[k]   <= 5'b11111;
      end
    end else begin
      FRAME_OK  <= w_commit;
      FRAME_ERR <= w_err;
      if (w_clr_cnt) begin
        r_cnt <= '0;
      end else if (w_shift_en) begin
        if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + 7'd1;
        if (w_byte_idx < 4'd8) begin
          if (w_bit_pos >= 3'd3)
            r_row_sr[w_byte_idx[2:0]] <= {r_row_sr[w_byte_idx[2:0]][3:0], w_di_s};
        end else if (w_byte_idx == 4'd8) begin
          r_joy_sr <= {r_joy_sr[6:0], w_di_s};
        end
      end
      if (w_commit) begin
        r_joy <= r_joy_sr;
        for (int k = 0; k < 8; k++) r_rows[k] <= r_row_sr[k];
      end
    end
  end

  always_comb begin
    w_keys = 5'b11111;
    for (int k = 0; k < 8; k++) begin
      if (!A[8+k]) w_keys = w_keys & r_rows[k];
    end
  end

  // A[0] splits the two ports, so the OEs are exclusive by construction.
  assign FE_OE = ~IORD_N & ~A[0];
  assign KJ_OE = ~IORD_N & A[0] & (A[7:0] == KJ_ADDR);
  assign DOUT  = FE_OE ? {1'b1, TAPE_IN, 1'b1, w_keys} :
                 KJ_OE ? r_joy : 8'hFF;

endmodule
`default_nettype wire

// File: doc/kbd_spi_port_reader.md
Name: kbd_spi_port_reader

Overview:
- Receive side of the keyboard/joystick link from the USB/PS2/SEGA controller (KBD_CS/KBD_CLK/KBD_DI SPI, controller is master).
- Deserialises frames into a shadowed 8x5 key matrix plus a Kempston byte.
- Answers CPU reads of port #FE (keys + TAPE_IN) and port #1F (joystick); the complementary direction to the existing port #FE write register.
- Sits beside the IO decode in the top-level CPLD and drives D only through its output-enable flags.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the KBD_CLK/KBD_CS/KBD_DI synchronisers (min 2).
- FRAME_BITS, 72, bits per valid frame: 8 row bytes then 1 joystick byte.
- KJ_ADDR, 8'h1F, low address byte decoded as the Kempston port.

Ports:
- CLK_14MHZ  in  1  system clock; all logic on posedge.
- CPU_RESET  in  1  reset, asynchronous, active-low.
- KBD_CLK  in  1  SPI clock from controller, data sampled on its rising edge; max 3.5 MHz.
- KBD_CS  in  1  frame select, active-low.
- KBD_DI  in  1  serial data, MSB first.
- A  in  16  CPU address.
- IORD_N  in  1  CPU_IORQ|CPU_RD, active-low IO read strobe.
- TAPE_IN  in  1  tape comparator input.
- FE_OE  out  1  high when this block must drive D for a #FE read.
- KJ_OE  out  1  high when this block must drive D for a #1F read.
- DOUT  out  8  data for D, valid while FE_OE or KJ_OE is high.
- FRAME_OK  out  1  one-clock pulse on each committed frame.
- FRAME_ERR  out  1  one-clock pulse on each discarded frame.

Behaviour:
- Reset (async, CPU_RESET=0):
  - all 40 matrix bits=1 (no key pressed), joystick byte=8'h00.
  - bit counter=0, shift register=0, synchronisers=1 (CLK/CS idle high).
  - FRAME_OK=FRAME_ERR=0, no commit pending.
- Synchronisers: KBD_CLK, KBD_CS and KBD_DI each pass through SYNC_STAGES flops. Rising edge of KBD_CLK = sync value 1 and previous 0.
- Receiver FSM:
  - IDLE: leave on synced CS falling edge → SHIFT, counter=0.
  - SHIFT: on each KBD_CLK rising edge with CS low, shift DI into the LSB and increment the counter; the counter saturates at 127 and does not wrap.
  - On CS rising edge in SHIFT:
    - counter==FRAME_BITS → COMMIT.
    - otherwise → pulse FRAME_ERR for one clock, return to IDLE, leave matrix untouched. This covers short frames, long frames and a 0-bit frame.
  - COMMIT:
    - if IORD_N==1, copy the shift register into the shadow (row k = byte k bits [4:0], byte 0 = row A8 … byte 7 = row A15; byte 8 = joystick), pulse FRAME_OK, go to IDLE.
    - if IORD_N==0, hold in COMMIT until IORD_N==1, so D never changes mid-read.
    - a new CS falling edge while in COMMIT is ignored until the commit completes.
  - Key bits are active-low, as in the matrix. Bits [7:5] of row bytes are ignored.
- Port #FE read:
  - FE_OE = ~IORD_N & ~A[0], combinational.
  - DOUT[4:0] = bitwise AND of all rows whose address line A[8+k]==0. If no line is low, DOUT[4:0]=5'b11111.
  - DOUT[5]=1, DOUT[6]=TAPE_IN (raw, unsynchronised), DOUT[7]=1.
- Port #1F read:
  - KJ_OE = ~IORD_N & (A[7:0]==KJ_ADDR) & A[0]. #FE has priority; KJ_OE can never be high together with FE_OE.
  - DOUT = joystick byte.
- When neither OE is high, DOUT=8'hFF.
- Reset asserted mid-frame aborts the frame immediately, with no FRAME_ERR pulse.

Test Plan:
- Reset, then read #FE with A=16'hFEFE, IORD_N=0, TAPE_IN=0 → FE_OE=1, DOUT=8'hBF. Read #1F → KJ_OE=1, DOUT=8'h00.
- Send a 72-bit frame with byte 0=8'hFE (CAPS SHIFT pressed), bytes 1-7=8'hFF, byte 8=8'h11 at 3.5 MHz.
  - FRAME_OK pulses once.
  - Read A=16'hFEFE → DOUT=8'hBE. Read A=16'hFDFE → DOUT=8'hBF. Read A=16'h001F → DOUT=8'h11.
- Multi-row select: frame with byte 0=8'hFE and byte 7=8'hEF, then read A=16'h7EFE → DOUT[4:0]=5'b01110.
- Send 71-bit and 73-bit frames → FRAME_ERR pulses each time; a subsequent #FE read returns the prior matrix unchanged.
- Hold IORD_N=0 on A=16'hFEFE while a valid frame ends → DOUT is stable through the read. Matrix and FRAME_OK update on the first clock after IORD_N rises.
- Assert CPU_RESET low after 40 bits of a frame, release, then send a full valid frame → no FRAME_ERR, matrix reads all 1s before the new frame, and the new frame commits normally.
